dmem_responder: RTL and testbench

Data-memory responder for the multicycle RISC-V core. It is the target side of the core's load/store port: it accepts one request at a time over a valid/ready handshake and stalls for a parameterised number of wait states. It then performs an RV32I-width access (byte, half or word, signed or unsigned) on an internal little-endian word array and returns read data or an error over a second valid/ready handshake.

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES stall states,
// RV32I byte/half/word access on a little-endian word array with error reporting.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid, once raised, holds its payload until that edge; ready may not
  // depend on valid of the same channel.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;
  logic [3:0]  cnt;

  logic [31:0] mem [DEPTH];

  logic          req_fire;
  logic          rsp_fire;
  logic          access;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          bad_funct3;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_value;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          do_write;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = (state == RESP) && rsp_ready;
  assign access   = (state == BUSY) && (cnt == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dbg_state = state;
    case (state)
      IDLE:    req_ready = !rst;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_wdata  <= 32'd0;
    end else if (req_fire) begin
      cnt        <= 4'(WAIT_CYCLES);
      lat_we     <= req_we;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Error classification of the latched request
  always_comb begin
    if (lat_we) begin
      bad_funct3 = (lat_funct3 > 3'd2);
    end else begin
      bad_funct3 = (lat_funct3 == 3'd3) || (lat_funct3 == 3'd6) || (lat_funct3 == 3'd7);
    end
    misaligned   = ((lat_funct3[1:0] == 2'd1) && lat_addr[0]) ||
                   ((lat_funct3[1:0] == 2'd2) && (lat_addr[1:0] != 2'd0));
    out_of_range = ({2'b00, lat_addr[31:2]} >= 32'(DEPTH));
    acc_err      = bad_funct3 || misaligned || out_of_range;
  end

  // Index is only meaningful when in range; out-of-range accesses never touch memory
  assign word_idx = lat_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  // Load lane selection and extension
  always_comb begin
    ld_byte = 8'd0;
    case (lat_addr[1:0])
      2'd0: ld_byte = rd_word[7:0];
      2'd1: ld_byte = rd_word[15:8];
      2'd2: ld_byte = rd_word[23:16];
      2'd3: ld_byte = rd_word[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_funct3)
      3'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_value = rd_word;
      3'd4:    ld_value = {24'd0, ld_byte};
      3'd5:    ld_value = {16'd0, ld_half};
      default: ld_value = 32'd0;
    endcase
  end

  // Store byte enables; data is replicated so every lane sees its field
  always_comb begin
    st_be   = 4'b0000;
    st_data = lat_wdata;
    case (lat_funct3[1:0])
      2'd0: begin
        st_be   = 4'b0001 << lat_addr[1:0];
        st_data = {4{lat_wdata[7:0]}};
      end
      2'd1: begin
        st_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{lat_wdata[15:0]}};
      end
      2'd2: begin
        st_be   = 4'b1111;
        st_data = lat_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = lat_wdata;
      end
    endcase
  end

  assign do_write = access && !rst && lat_we && !acc_err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  // Response registers hold their value through RESP until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || lat_we) ? 32'd0 : ld_value;
    end else if (rsp_fire) begin
      rsp_rdata <= rsp_rdata;
      rsp_err   <= rsp_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// backpressure and reset corner cases, then random traffic against a byte model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAIT  = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [4*DEPTH];
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the memory is a flat byte array; access rules straight
  // from the RV32I load/store definitions.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int    nbytes;
    bit    illegal;
    longint a;
    logic [31:0] v;
    a = longint'(addr);
    if (we) illegal = (f3 > 2);
    else    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    nbytes = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    err = illegal || ((a % nbytes) != 0) || (a >= 4 * DEPTH);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) begin
          for (int i = 8 * nbytes; i < 32; i++) v[i] = 1'b1;
        end
        rd = v;
      end
    end
  endtask

  // Driver: one full transaction, called and returning on a falling edge.
  // hold = number of cycles rsp_ready stays low after rsp_valid rises; during
  // those cycles a competing request is presented and must not be taken.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_wait: req_ready never rose");
    end
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    req_wdata  = $urandom;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(WAIT + 1));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, er});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_req_ready", {31'd0, req_ready}, 32'd1);
    chk("done_state_idle", {30'd0, dbg_state}, 32'd0);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, mrd;
    logic        er, merr;
    logic        we;
    logic [31:0] addr, wd;
    logic [2:0]  f3;
    int          n;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
    req_wdata = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_rdata", rsp_rdata, 32'd0);
    chk("idle_err", {31'd0, rsp_err}, 32'd0);

    // Known contents for the low region used by all later phases
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      ref_access(1'b1, 32'(4 * w), 3'd2, wd, mrd, merr);
      xact(1'b1, 32'(4 * w), 3'd2, wd, 0, rd, er);
    end

    vecs.push_back('{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h13, 3'd0, 32'h0,        32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 32'h13, 3'd4, 32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 3'd1, 32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h12, 3'd5, 32'h0,        32'h0000DEAD, 1'b0});
    vecs.push_back('{1'b1, 32'h11, 3'd0, 32'h12,       32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h12, 3'd1, 32'h5678,     32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10, 3'd2, 32'h0,        32'h567812EF, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h11, 3'd2, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h03, 3'd1, 32'hFFFF,     32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h00, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 32'(4*DEPTH), 3'd2, 32'h0,  32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10, 3'd3, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10, 3'd4, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10, 3'd2, 32'h0,        32'h567812EF, 1'b0});
    vecs.push_back('{1'b0, 32'h0F, 3'd4, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h20, 3'd2, 32'h11111111, 32'h0,        1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      ref_access(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, mrd, merr);
      // Vector 17 reads an untouched prefilled byte: its value comes from the model
      if (i == 17) vecs[i].exp_rd = mrd;
      xact(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Backpressure: rsp_ready low for 5 cycles after rsp_valid
    xact(1'b0, 32'h10, 3'd2, 32'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'h567812EF);
    chk("bp_err", {31'd0, er}, 32'd0);

    // Reset on the access edge of a store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2;
    req_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (WAIT) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_mid_no_rsp", 32'(n), 32'd0);
    chk("rst_mid_idle", {30'd0, dbg_state}, 32'd0);
    xact(1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er);
    chk("rst_mid_mem_kept", rd, 32'h11111111);

    // Random traffic against the model; expected results go through a queue
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 63));
      endcase
      wd = $urandom;
      ref_access(we, addr, f3, wd, mrd, merr);
      exp_q.push_back(mrd);
      exp_q.push_back({31'd0, merr});
      xact(we, addr, f3, wd, $urandom_range(0, 2), rd, er);
      chk($sformatf("rnd%0d_rdata", t), rd, exp_q.pop_front());
      chk($sformatf("rnd%0d_err", t), {31'd0, er}, exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
